// File: rtl/qdrc_pkg.sv
// qdrc_pkg: definitions shared by the QDR controller command path.
//   qdrc_state_e     scheduler FSM state encodings (INIT/RUN/QUIESCE)
//   QDRC_RD_LATENCY  default PHY read latency in clk cycles, shared with the PHY
//   clog2()          ceiling log2 for sizing pointers and counters
package qdrc_pkg;

  localparam int unsigned QDRC_RD_LATENCY = 10;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_QUIESCE = 2'd2
  } qdrc_state_e;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qdrc_cmd_sched_if.sv
// qdrc_cmd_sched_if: user-side request/return bundle of the QDR command scheduler.
//   usr_wr_en/rdy/addr/data      write request handshake
//   usr_rd_en/rdy/addr/tag       read request handshake
//   usr_rd_dvld/data/err/tag_o   read data return
// Modports: master = user logic, slave = scheduler.
interface qdrc_cmd_sched_if #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned TAG_WIDTH  = 4
) ();

  logic                    usr_wr_en;
  logic                    usr_wr_rdy;
  logic [ADDR_WIDTH-1:0]   usr_wr_addr;
  logic [2*DATA_WIDTH-1:0] usr_wr_data;
  logic                    usr_rd_en;
  logic                    usr_rd_rdy;
  logic [ADDR_WIDTH-1:0]   usr_rd_addr;
  logic [TAG_WIDTH-1:0]    usr_rd_tag;
  logic                    usr_rd_dvld;
  logic [2*DATA_WIDTH-1:0] usr_rd_data;
  logic                    usr_rd_err;
  logic [TAG_WIDTH-1:0]    usr_rd_tag_o;

  modport master (
    output usr_wr_en, usr_wr_addr, usr_wr_data, usr_rd_en, usr_rd_addr, usr_rd_tag,
    input  usr_wr_rdy, usr_rd_rdy, usr_rd_dvld, usr_rd_data, usr_rd_err, usr_rd_tag_o
  );

  modport slave (
    input  usr_wr_en, usr_wr_addr, usr_wr_data, usr_rd_en, usr_rd_addr, usr_rd_tag,
    output usr_wr_rdy, usr_rd_rdy, usr_rd_dvld, usr_rd_data, usr_rd_err, usr_rd_tag_o
  );

endinterface

// File: rtl/qdrc_req_fifo.sv
// qdrc_req_fifo: synchronous request FIFO, first-word-fall-through read port.
//   clk, reset_n  clock, async active-low reset (pointers only)
//   push, din     write side; push ignored when full
//   pop, dout     read side; dout shows head entry, pop ignored when empty
//   full, empty   status; a pushed entry becomes visible the cycle after push
module qdrc_req_fifo
  import qdrc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = clog2(DEPTH);

  // Pointers carry one wrap bit to tell full from empty.
  logic [PW:0]      wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty = (wp == rp);
  assign dout  = mem[rp[PW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (PW+1)'(1);
      if (pop && !empty) rp <= rp + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[PW-1:0]] <= din;
  end

endmodule

// File: rtl/qdrc_cmd_sched.sv
// qdrc_cmd_sched: command scheduler in front of the QDR soft-cal PHY.
// Buffers user writes/reads, issues one command per clk onto the shared PHY
// address bus, and returns read data RD_LATENCY+1 clk after the read strobe.
// Ports:
//   clk, reset_n     controller clock, async active-low reset
//   phy_rdy          PHY ready, low while calibration owns the PHY
//   phy_wr_strb/rd_strb, phy_addr, phy_wr_data   registered PHY command
//   phy_rd_data      PHY read data, valid RD_LATENCY clk after phy_rd_strb
//   usr              qdrc_cmd_sched_if.slave user request/return bundle
// Build option: define QDRC_SCHED_RD_TAG_EN to carry usr_rd_tag through to
// usr_rd_tag_o; otherwise usr_rd_tag_o is tied to zero.
module qdrc_cmd_sched
  import qdrc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned RD_LATENCY = QDRC_RD_LATENCY,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    phy_rdy,
  output logic                    phy_wr_strb,
  output logic                    phy_rd_strb,
  output logic [ADDR_WIDTH-1:0]   phy_addr,
  output logic [2*DATA_WIDTH-1:0] phy_wr_data,
  input  logic [2*DATA_WIDTH-1:0] phy_rd_data,
  qdrc_cmd_sched_if.slave         usr
);

  localparam int unsigned DW2   = 2 * DATA_WIDTH;
  localparam int unsigned WFW   = ADDR_WIDTH + DW2;
  localparam int unsigned CNT_W = clog2(RD_LATENCY + 2);
`ifdef QDRC_SCHED_RD_TAG_EN
  localparam int unsigned RFW = ADDR_WIDTH + TAG_WIDTH;
`else
  localparam int unsigned RFW = ADDR_WIDTH;
`endif

  qdrc_state_e      state, state_nxt;
  logic             issue_en;
  logic             wr_full, wr_empty, rd_full, rd_empty;
  logic             wr_pop, rd_pop;
  logic             last_rd;
  logic [WFW-1:0]   wr_q;
  logic [RFW-1:0]   rd_q, rd_din;
  logic [CNT_W-1:0] inflight;
  logic [RD_LATENCY:0] vld_sr, err_sr;

  // ---------------- request FIFOs ----------------
  assign usr.usr_wr_rdy = !wr_full;
  assign usr.usr_rd_rdy = !rd_full;

`ifdef QDRC_SCHED_RD_TAG_EN
  assign rd_din = {usr.usr_rd_addr, usr.usr_rd_tag};
`else
  assign rd_din = usr.usr_rd_addr;
`endif

  qdrc_req_fifo #(.WIDTH(WFW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(usr.usr_wr_en), .din({usr.usr_wr_addr, usr.usr_wr_data}),
    .pop(wr_pop), .dout(wr_q), .full(wr_full), .empty(wr_empty)
  );

  qdrc_req_fifo #(.WIDTH(RFW), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(usr.usr_rd_en), .din(rd_din),
    .pop(rd_pop), .dout(rd_q), .full(rd_full), .empty(rd_empty)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:    if (phy_rdy)         state_nxt = ST_RUN;
      ST_RUN:     if (!phy_rdy)        state_nxt = ST_QUIESCE;
      ST_QUIESCE: if (inflight == '0)  state_nxt = ST_INIT;
      default:                         state_nxt = ST_INIT;
    endcase
  end

  // Issue is cut in the very cycle phy_rdy is seen low, before RUN exits.
  always_comb begin
    issue_en = (state == ST_RUN) && phy_rdy;
  end

  // ---------------- arbitration ----------------
  // Ties alternate on last_rd; reset to "read last" so a write wins the first tie.
  always_comb begin
    wr_pop = 1'b0;
    rd_pop = 1'b0;
    if (issue_en) begin
      if (!wr_empty && (rd_empty || last_rd)) wr_pop = 1'b1;
      else if (!rd_empty)                     rd_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_rd     <= 1'b1;
      phy_wr_strb <= 1'b0;
      phy_rd_strb <= 1'b0;
      phy_addr    <= '0;
      phy_wr_data <= '0;
    end else begin
      phy_wr_strb <= wr_pop;
      phy_rd_strb <= rd_pop;
      if (wr_pop) begin
        last_rd     <= 1'b0;
        phy_addr    <= wr_q[WFW-1 -: ADDR_WIDTH];
        phy_wr_data <= wr_q[DW2-1:0];
      end else if (rd_pop) begin
        last_rd  <= 1'b1;
        phy_addr <= rd_q[RFW-1 -: ADDR_WIDTH];
      end
    end
  end

  // ---------------- read return ----------------
  // vld_sr[k] is high k+1 clk after a read strobe; err_sr[k] accumulates any
  // phy_rdy-low cycle seen since that strobe, only while the stage is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr          <= '0;
      err_sr          <= '0;
      inflight        <= '0;
      usr.usr_rd_data <= '0;
    end else begin
      vld_sr    <= {vld_sr[RD_LATENCY-1:0], phy_rd_strb};
      err_sr[0] <= phy_rd_strb & ~phy_rdy;
      for (int unsigned i = 1; i <= RD_LATENCY; i++) begin
        err_sr[i] <= vld_sr[i-1] & (err_sr[i-1] | ~phy_rdy);
      end
      if (vld_sr[RD_LATENCY-1]) usr.usr_rd_data <= phy_rd_data;
      case ({phy_rd_strb, vld_sr[RD_LATENCY]})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign usr.usr_rd_dvld = vld_sr[RD_LATENCY];
  assign usr.usr_rd_err  = err_sr[RD_LATENCY];

`ifdef QDRC_SCHED_RD_TAG_EN
  logic [TAG_WIDTH-1:0] rd_tag_q;
  logic [TAG_WIDTH-1:0] tag_sr [RD_LATENCY+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_tag_q <= '0;
      for (int unsigned i = 0; i <= RD_LATENCY; i++) tag_sr[i] <= '0;
    end else begin
      if (rd_pop) rd_tag_q <= rd_q[TAG_WIDTH-1:0];
      tag_sr[0] <= rd_tag_q;
      for (int unsigned i = 1; i <= RD_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign usr.usr_rd_tag_o = tag_sr[RD_LATENCY];
`else
  logic unused_rd_tag;
  assign unused_rd_tag    = ^usr.usr_rd_tag;
  assign usr.usr_rd_tag_o = '0;
`endif

endmodule
